// File: rtl/limn2600_bus_arbiter_pkg.sv
// Shared types and constants for the Limn2600 SRAM bus arbiter.
// Latency/backpressure: n/a (declarations only).
package limn2600_bus_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic req_idx_t;

  // A lone requester always wins; on a tie the one not served last goes next.
  function automatic req_idx_t rr_pick(input logic cs0, input logic cs1, input req_idx_t last);
    req_idx_t pick;
    if (cs0 && cs1) pick = ~last;
    else            pick = cs1;
    return pick;
  endfunction

endpackage

// File: rtl/limn2600_bus_arbiter_if.sv
// One cs/we/addr/wdata -> rdata/rdy/err channel of the Limn2600 SRAM bus.
// Latency: wires only; backpressure: cs is held until the matching rdy pulse.
interface limn2600_bus_arbiter_if
  import limn2600_bus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdy;
  logic              err;  // driven only towards requesters; the SRAM side has no error line

  modport master (output cs, we, addr, wdata, input rdata, rdy);
  modport slave  (input cs, we, addr, wdata, output rdata, rdy, err);

endinterface

// File: rtl/limn2600_bus_arbiter_watchdog.sv
// Counts BUSY cycles and flags the TIMEOUT-th one; saturates instead of wrapping.
// Latency: expired is combinational from the count; no backpressure.
module limn2600_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/limn2600_bus_arbiter.sv
// Round-robin arbiter sharing the SRAM port between CPU (m0) and a second master (m1).
// Latency: grant one cycle after cs; completion is combinational from s.rdy; requesters wait on rdy.
module limn2600_bus_arbiter
  import limn2600_bus_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst,
  limn2600_bus_arbiter_if.slave  m0,
  limn2600_bus_arbiter_if.slave  m1,
  limn2600_bus_arbiter_if.master s
);

  arb_state_t        state;
  req_idx_t          grant;
  req_idx_t          last;
  logic              busy;
  logic              expired;
  logic              done;
  logic              timed_out;
  logic [DATA_W-1:0] done_data;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  assign busy = (state == ARB_BUSY);

  limn2600_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // A slave answer in the expiry cycle still counts as a good completion.
  // A transaction caught by reset is abandoned silently.
  assign done      = busy && !rst && (s.rdy || expired);
  assign timed_out = !s.rdy && expired;
  assign done_data = s.rdy ? s.rdata : DATA_W'(BUS_ERR_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0.cs || m1.cs) begin
            grant <= rr_pick(m0.cs, m1.cs, last);
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            last  <= grant;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (busy) begin
      if (grant) begin
        mux_we    = m1.we;
        mux_addr  = m1.addr;
        mux_wdata = m1.wdata;
      end else begin
        mux_we    = m0.we;
        mux_addr  = m0.addr;
        mux_wdata = m0.wdata;
      end
    end
  end

  always_comb begin
    s.cs    = busy;
    s.we    = mux_we;
    s.addr  = mux_addr;
    s.wdata = mux_wdata;

    m0.rdy   = done && (grant == 1'b0);
    m0.err   = m0.rdy && timed_out;
    m0.rdata = m0.rdy ? done_data : '0;

    m1.rdy   = done && (grant == 1'b1);
    m1.err   = m1.rdy && timed_out;
    m1.rdata = m1.rdy ? done_data : '0;
  end

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Scoreboard bench: requesters and a latency-programmable SRAM model feed a transaction-level
// reference; an independent monitor checks every completion and the bus idle/gap rules.
module tb_limn2600_bus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  limn2600_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  limn2600_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  limn2600_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  limn2600_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   act_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // requester and slave model state
  logic        cs_r[2];
  logic        we_r[2];
  logic [31:0] addr_r[2];
  logic [31:0] wdata_r[2];
  logic        hold[2];
  logic        got[2];
  logic        prev_cs[2];
  logic        rst_q;
  logic        rnd_mode;
  logic        stray;
  logic        mon_en;
  logic        slv_act;
  int          slv_n;
  int          slv_lat;
  int          slv_owner;
  logic [31:0] slv_dat;
  int          force_lat;
  logic        force_dat_en;
  logic [31:0] force_dat;
  int          model_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cs_r[i]    = 1'b1;
    we_r[i]    = we;
    addr_r[i]  = addr;
    wdata_r[i] = wdata;
  endtask

  task automatic new_req(input int i);
    set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
  endtask

  // One bus cycle: requester decisions, slave response, then sample rdy for next cycle.
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_q;
    for (int i = 0; i < 2; i++) begin
      if (cs_r[i] && got[i]) begin
        if (!hold[i]) begin
          if (rnd_mode && ($urandom_range(1, 0) == 1)) new_req(i);
          else cs_r[i] = 1'b0;
        end
      end else if (!cs_r[i] && rnd_mode && ($urandom_range(3, 0) == 0)) begin
        new_req(i);
      end
    end

    if (s_if.cs) begin
      if (!slv_act) begin
        slv_act = 1'b1;
        slv_n   = 0;
        slv_lat = (force_lat > 0) ? force_lat : int'($urandom_range(TO + 2, 1));
        slv_dat = force_dat_en ? force_dat : $urandom;
        chk("grant_had_request", {63'd0, prev_cs[0] | prev_cs[1]}, 64'd1);
        if (prev_cs[0] && prev_cs[1]) slv_owner = 1 - model_last;
        else if (prev_cs[1])          slv_owner = 1;
        else                          slv_owner = 0;
        model_last = slv_owner;
        exp_q.push_back('{slv_owner,
                          (slv_lat > TO) ? 32'hFFFF_FFFF : slv_dat,
                          (slv_lat > TO),
                          cyc + ((slv_lat > TO) ? TO : slv_lat) - 1});
      end
      slv_n++;
      chk("s_we",    {63'd0, s_if.we}, {63'd0, we_r[slv_owner]});
      chk("s_addr",  {32'd0, s_if.addr}, {32'd0, addr_r[slv_owner]});
      chk("s_wdata", {32'd0, s_if.wdata}, {32'd0, wdata_r[slv_owner]});
      s_if.rdy   = (slv_n == slv_lat);
      s_if.rdata = s_if.rdy ? slv_dat : $urandom;
    end else begin
      slv_act    = 1'b0;
      s_if.rdy   = stray || (rnd_mode && ($urandom_range(7, 0) == 0));
      s_if.rdata = $urandom;
    end

    m0_if.cs = cs_r[0]; m0_if.we = we_r[0]; m0_if.addr = addr_r[0]; m0_if.wdata = wdata_r[0];
    m1_if.cs = cs_r[1]; m1_if.we = we_r[1]; m1_if.addr = addr_r[1]; m1_if.wdata = wdata_r[1];
    prev_cs[0] = cs_r[0];
    prev_cs[1] = cs_r[1];

    @(negedge clk);
    got[0] = m0_if.rdy;
    got[1] = m1_if.rdy;
  endtask

  task automatic run_until_quiet(input int budget);
    int n;
    n = 0;
    step();
    while ((cs_r[0] || cs_r[1] || s_if.cs || (exp_q.size() != 0)) && (n < budget)) begin
      step();
      n++;
    end
    chk("drain_in_budget", {63'd0, n < budget}, 64'd1);
  endtask

  // Monitor: pops the scoreboard on every completion and checks idle/gap/latency rules.
  initial begin : monitor
    exp_t e;
    int   owner;
    logic p_scs = 1'b0;
    logic p_any = 1'b0;
    logic p_rdy = 1'b0;
    logic p_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          chk("no_rdy_in_reset", {62'd0, m1_if.rdy, m0_if.rdy}, 64'd0);
        end else begin
          if (m0_if.rdy || m1_if.rdy) begin
            chk("single_rdy", {63'd0, m0_if.rdy & m1_if.rdy}, 64'd0);
            owner = m1_if.rdy ? 1 : 0;
            act_log.push_back(owner);
            if (exp_q.size() == 0) begin
              chk("unexpected_rdy", {62'd0, m1_if.rdy, m0_if.rdy}, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("rdy_owner", owner, e.owner);
              chk("rdy_cycle", cyc, e.cyc);
              chk("rdata", {32'd0, owner ? m1_if.rdata : m0_if.rdata}, {32'd0, e.rdata});
              chk("err", {63'd0, owner ? m1_if.err : m0_if.err}, {63'd0, e.err});
            end
          end else if ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc)) begin
            e = exp_q.pop_front();
            chk("missing_rdy", {62'd0, m1_if.rdy, m0_if.rdy}, (e.owner == 1) ? 64'd2 : 64'd1);
          end
          if (!m0_if.rdy) chk("m0_quiet", {31'd0, m0_if.err, m0_if.rdata}, 64'd0);
          if (!m1_if.rdy) chk("m1_quiet", {31'd0, m1_if.err, m1_if.rdata}, 64'd0);
          if (!s_if.cs) begin
            chk("s_idle_we_addr", {31'd0, s_if.we, s_if.addr}, 64'd0);
            chk("s_idle_wdata", {32'd0, s_if.wdata}, 64'd0);
          end
          if (!p_rst) begin
            if (p_rdy)       chk("s_cs_gap", {63'd0, s_if.cs}, 64'd0);
            else if (!p_scs) chk("arb_latency", {63'd0, s_if.cs}, {63'd0, p_any});
          end
        end
        p_scs = s_if.cs;
        p_any = m0_if.cs | m1_if.cs;
        p_rdy = m0_if.rdy | m1_if.rdy;
        p_rst = rst;
      end
    end
  end

  initial begin
    rst = 1'b1; rst_q = 1'b1; rnd_mode = 1'b0; stray = 1'b0; mon_en = 1'b0;
    slv_act = 1'b0; slv_n = 0; slv_lat = 0; slv_owner = 0; slv_dat = '0;
    force_lat = 0; force_dat_en = 1'b0; force_dat = '0; model_last = 1;
    for (int i = 0; i < 2; i++) begin
      cs_r[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0;
      hold[i] = 1'b0; got[i] = 1'b0; prev_cs[i] = 1'b0;
    end
    m0_if.cs = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.cs = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    s_if.rdy = 1'b0; s_if.rdata = '0; s_if.err = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_s_cs_we", {62'd0, s_if.cs, s_if.we}, 64'd0);
    chk("rst_s_addr", {32'd0, s_if.addr}, 64'd0);
    chk("rst_s_wdata", {32'd0, s_if.wdata}, 64'd0);
    chk("rst_m0", {30'd0, m0_if.rdy, m0_if.err, m0_if.rdata}, 64'd0);
    chk("rst_m1", {30'd0, m1_if.rdy, m1_if.err, m1_if.rdata}, 64'd0);
    rst_q = 1'b0;
    mon_en = 1'b1;
    step();

    // m0 read 0x100, slave answers 0xDEADBEEF in the second BUSY cycle
    force_lat = 2; force_dat_en = 1'b1; force_dat = 32'hDEAD_BEEF;
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    run_until_quiet(30);
    force_dat_en = 1'b0;

    // both held high: grants alternate, starting with m1 since m0 was served last
    act_log.delete();
    force_lat = 3;
    hold[0] = 1'b1; hold[1] = 1'b1;
    set_req(0, 1'b0, 32'h0000_1000, 32'h0);
    set_req(1, 1'b1, 32'h0000_2000, 32'hA5A5_5A5A);
    repeat (40) step();
    hold[0] = 1'b0; hold[1] = 1'b0;
    run_until_quiet(60);
    chk("rr_enough_grants", {63'd0, act_log.size() >= 8}, 64'd1);
    for (int i = 0; i < act_log.size(); i++) chk("rr_alternate", act_log[i], (i % 2 == 0) ? 1 : 0);

    // m1 write 0x40 / 0x12345678
    force_lat = 4;
    set_req(1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    run_until_quiet(30);

    // slave never answers: error completion in the TIMEOUT-th BUSY cycle
    force_lat = 100;
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    run_until_quiet(30);

    // slave answers exactly in the expiry cycle: good completion
    force_lat = TO;
    set_req(1, 1'b0, 32'h0000_0304, 32'h0);
    run_until_quiet(30);

    // s_rdy while idle is ignored
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stray_ignored", {62'd0, m1_if.rdy, m0_if.rdy}, 64'd0);
    end
    stray = 1'b0;

    // reset in the second BUSY cycle abandons the transaction
    force_lat = 5;
    set_req(0, 1'b0, 32'h0000_0200, 32'h0);
    for (int k = 0; (k < 6) && !slv_act; k++) step();
    chk("reset_setup_busy", {63'd0, s_if.cs}, 64'd1);
    cs_r[0] = 1'b0;
    rst_q = 1'b1;
    step();
    rst_q = 1'b0;
    exp_q.delete();
    model_last = 1;
    step();
    chk("post_rst_s", {30'd0, s_if.cs, s_if.we, s_if.addr}, 64'd0);
    chk("post_rst_wdata", {32'd0, s_if.wdata}, 64'd0);
    chk("post_rst_rdy", {60'd0, m1_if.rdy, m1_if.err, m0_if.rdy, m0_if.err}, 64'd0);
    act_log.delete();
    force_lat = 2;
    set_req(0, 1'b0, 32'h0000_0010, 32'h0);
    set_req(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    run_until_quiet(30);
    chk("post_rst_grants", act_log.size(), 2);
    chk("post_rst_first_tie", (act_log.size() > 0) ? act_log[0] : -1, 0);

    // randomized traffic, latencies spanning both sides of the timeout
    force_lat = 0;
    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    run_until_quiet(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
